masked_share_gen: RTL
=====================

Name: masked_share_gen

Overview:
- Upstream feeder for the 2-share masked half-adder datapath.
- Accepts plain W-bit operands a, b and streams them LSB-first, one bit per beat, as Boolean shares (A0,A1,B0,B1) plus one fresh refresh bit r0 per beat.
- Masks and r0 come from an internal 32-bit Galois LFSR.
- All share outputs are registered so the downstream masked AND sees glitch-free, stable shares.

Parameters:
- W, 8, operand width in bits (1..32); also the beat count per transaction.
- SEED, 32'h0000_0005, LFSR reset/default seed; must be nonzero.
- POLY, 32'h8020_0003, Galois feedback taps (x^32+x^22+x^2+x+1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block accepts an operand pair this cycle.
- a  in  W  plain operand A.
- b  in  W  plain operand B.
- seed_load  in  1  reseed request; honoured only in IDLE.
- seed_in  in  32  new LFSR state; 0 is replaced by SEED.
- out_valid  out  1  share beat valid.
- out_ready  in  1  downstream consumes the beat.
- A0, A1, B0, B1  out  1 each  shares of a[i], b[i].
- r0  out  1  fresh refresh bit for the masked AND.
- out_last  out  1  marks beat i = W-1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE and lfsr loads SEED.
  - Operand registers, idx, A0..r0, out_valid and out_last all clear to 0.
  - Applies mid-transaction too: any partial stream is dropped and no further beats are emitted.
- Mask mapping from the current lfsr state: mA=lfsr[0], mB=lfsr[1], r0=lfsr[2].
  - A0=a[i]^mA, A1=mA, B0=b[i]^mB, B1=mB.
- Beat load = registering A0..r0 and out_last from the current lfsr, then advancing lfsr by exactly 3 Galois steps.
  - The LFSR advances only on a beat load, never while idle or stalled. This keeps the stream deterministic for a given seed.
- FSM IDLE:
  - in_ready = ~seed_load.
  - seed_load=1: lfsr <= (seed_in==0 ? SEED : seed_in); no operand is accepted that cycle.
  - in_valid & in_ready: latch a and b, idx<=0, load beat 0, go to SEND.
  - Latency: handshake at edge t gives out_valid=1 from cycle t+1.
- FSM SEND:
  - in_ready=0; seed_load is ignored; out_valid=1.
  - out_ready=0: all outputs and the lfsr hold their values, bit-exact.
  - Handshake with idx<W-1: idx<=idx+1 and load beat idx+1 on the same edge, so back-to-back beats go out with no bubble.
  - Handshake with idx=W-1 (out_last=1): go to IDLE, out_valid<=0, out_last<=0.
  - in_ready rises the cycle after the final beat; no same-cycle overlap of last beat and next accept.
- Invariants checked every beat:
  - A0^A1 == a[idx] and B0^B1 == b[idx].
  - out_last == (idx==W-1).
- W=1: a single beat with out_last=1.
- No combinational path from in_valid or out_ready to any share output.

Decomposition:
- Package masked_pkg holds:
  - LFSR_W=32, default POLY and SEED.
  - State enum {IDLE, SEND}.
  - A function lfsr_step3(state, poly) returning the state advanced 3 Galois steps.
- One natural sub-module: masked_lfsr.
  - Holds the 32-bit register with load, advance-by-3, zero-seed substitution and synchronous reset to SEED.
  - Exposes the current state bits [2:0].
- The top level keeps the FSM, idx counter, operand registers and output registers.

Test Plan:
- Reset then W=4, a=4'b1011, b=4'b0110, out_ready=1 → out_valid rises 1 cycle after accept; recombined A bits 1,1,0,1 and B bits 0,1,1,0 over 4 consecutive beats; out_last only on beat 3; in_ready=1 the cycle after.
- Default SEED=5, first transaction → beat 0 has A1=1, B1=0, r0=1. Beat 1 masks equal bits [2:0] of lfsr_step3(5) from the package model.
- out_ready toggled 1,0,0,1,… mid-stream → outputs and lfsr frozen during stalls; the mask sequence is identical to the no-stall run.
- seed_load=1 with seed_in=0 and in_valid=1 in IDLE → in_ready=0 that cycle, lfsr=SEED; next cycle the operand is accepted with beat-0 masks from SEED. Then seed_in=32'hDEAD_BEEF → beat-0 mA=1, mB=1, r0=1.
- seed_load asserted during SEND → ignored; the stream continues unchanged.
- rst_n=0 at beat 2 of a W=8 stream → next cycle out_valid=0, in_ready=1, lfsr=SEED. A new transaction then reproduces the beat-0 masks of the post-reset run.

Source files
------------

// File: rtl/masked_share_gen_pkg.sv
// Shared types, defaults and LFSR helper for the masked share generator.
package masked_pkg;

  localparam int unsigned LFSR_W = 32;

  localparam logic [LFSR_W-1:0] DEF_POLY = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] DEF_SEED = 32'h0000_0005;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // Right-shifting Galois LFSR advanced by three steps (one per mask/refresh bit consumed).
  function automatic logic [LFSR_W-1:0] lfsr_step3(input logic [LFSR_W-1:0] state,
                                                   input logic [LFSR_W-1:0] poly);
    logic [LFSR_W-1:0] s;
    s = state;
    for (int unsigned i = 0; i < 3; i++) begin
      s = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? poly : '0);
    end
    return s;
  endfunction

endpackage

// File: rtl/masked_share_gen_lfsr.sv
// 32-bit Galois LFSR: reset to SEED, reload (zero replaced by SEED), advance by 3.
module masked_lfsr
  import masked_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
  parameter logic [LFSR_W-1:0] POLY = DEF_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              adv_i,
  output logic [2:0]        bits_o
);

  logic [LFSR_W-1:0] lfsr_q;

  // State register; load has priority over advance, the top never asserts both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (load_i) begin
      lfsr_q <= (seed_i == '0) ? SEED : seed_i;
    end else if (adv_i) begin
      lfsr_q <= lfsr_step3(lfsr_q, POLY);
    end
  end

  assign bits_o = lfsr_q[2:0];

endmodule

// File: rtl/masked_share_gen.sv
// Streams operands a,b LSB-first as registered 2-share Boolean bits plus a refresh bit.
module masked_share_gen
  import masked_pkg::*;
#(
  parameter int unsigned       W    = 8,
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
  parameter logic [LFSR_W-1:0] POLY = DEF_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              A0,
  output logic              A1,
  output logic              B0,
  output logic              B1,
  output logic              r0,
  output logic              out_last
);

  localparam int unsigned      IDX_W    = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
  logic             a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d, r0_q, r0_d;
  logic             last_q, last_d, valid_q, valid_d;

  logic             lfsr_load, beat_en, beat_a, beat_b, beat_last;
  logic [2:0]       mask;

  masked_lfsr #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (lfsr_load),
    .seed_i (seed_in),
    .adv_i  (beat_en),
    .bits_o (mask)
  );

  // Next-state: FSM, operand capture and beat load from the current LFSR masks.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    a0_d      = a0_q;
    a1_d      = a1_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    r0_d      = r0_q;
    last_d    = last_q;
    valid_d   = valid_q;
    in_ready  = 1'b0;
    lfsr_load = 1'b0;
    beat_en   = 1'b0;
    beat_a    = 1'b0;
    beat_b    = 1'b0;
    beat_last = 1'b0;
    nxt_idx   = idx_q + IDX_W'(1);

    unique case (state_q)
      IDLE: begin
        in_ready = ~seed_load;
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (in_valid) begin
          a_d       = a;
          b_d       = b;
          idx_d     = '0;
          beat_en   = 1'b1;
          beat_a    = a[0];
          beat_b    = b[0];
          beat_last = (LAST_IDX == '0);
          state_d   = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d     = nxt_idx;
            beat_en   = 1'b1;
            beat_a    = a_q[nxt_idx];
            beat_b    = b_q[nxt_idx];
            beat_last = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_en) begin
      a1_d    = mask[0];
      a0_d    = beat_a ^ mask[0];
      b1_d    = mask[1];
      b0_d    = beat_b ^ mask[1];
      r0_d    = mask[2];
      last_d  = beat_last;
      valid_d = 1'b1;
    end
  end

  // Registered state and share outputs; reset drops any partial stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      a0_q    <= 1'b0;
      a1_q    <= 1'b0;
      b0_q    <= 1'b0;
      b1_q    <= 1'b0;
      r0_q    <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      r0_q    <= r0_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign A0        = a0_q;
  assign A1        = a1_q;
  assign B0        = b0_q;
  assign B1        = b1_q;
  assign r0        = r0_q;

endmodule
